// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Line-oriented UART command controller. Collects and edits an
//            ASCII line, parses "rd AAAA" / "wr AAAA DD" / "stop", performs
//            one register-bus access and returns a CRLF-terminated reply.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int LINE_MAX = 16,  // must be >= 10 to hold a write command
  parameter int RD_LAT   = 2,
  parameter int TX_GAP   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        iRX_DE,
  input  logic [7:0]  iRX_DATA,
  output logic        oTX_DE,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_BUSY,
  output logic [15:0] oREG_ADDR,
  output logic [7:0]  oREG_WDATA,
  output logic        oREG_WE,
  output logic        oREG_RE,
  input  logic [7:0]  iREG_RDATA,
  output logic        oSTOP,
  output logic        oOVERRUN
);

  localparam int CNT_W = $clog2(LINE_MAX + 1);
  localparam int IDX_W = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int GAP_W = $clog2(TX_GAP + 1);
  localparam logic [CNT_W-1:0] c_line_max = CNT_W'(LINE_MAX);
  localparam logic [LAT_W-1:0] c_rd_lat   = LAT_W'(RD_LAT);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(TX_GAP - 1);

  typedef enum logic [2:0] {
    S_COLLECT = 3'd0,
    S_PARSE   = 3'd1,
    S_READ    = 3'd2,
    S_WRITE   = 3'd3,
    S_TX      = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_buf [LINE_MAX];
  logic [CNT_W-1:0]   r_cnt;
  logic               r_lerr;
  logic [15:0]        r_addr;
  logic [7:0]         r_wdata;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [7:0]         r_rep0, r_rep1;
  logic [1:0]         r_tx_idx;
  logic               r_in_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_tx_de;
  logic [7:0]         r_tx_data;
  logic               r_overrun;

  // Decode one ASCII hex digit: {valid, nibble}. Letters are case-insensitive.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
                                       return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  // Nibble to uppercase ASCII hex.
  function automatic logic [7:0] to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [4:0] w_h3, w_h4, w_h5, w_h6, w_h8, w_h9;
  logic       w_rd_ok, w_wr_ok, w_stop_ok;
  logic       w_is_bs, w_is_eol, w_line_empty;
  logic [7:0] w_tx_byte;

  assign w_h3 = hex_nib(r_buf[3]);
  assign w_h4 = hex_nib(r_buf[4]);
  assign w_h5 = hex_nib(r_buf[5]);
  assign w_h6 = hex_nib(r_buf[6]);
  assign w_h8 = hex_nib(r_buf[8]);
  assign w_h9 = hex_nib(r_buf[9]);

  // Exact-match parsers; a line with an overflow error never matches.
  assign w_rd_ok = !r_lerr && (r_cnt == CNT_W'(7)) &&
                   (r_buf[0] == 8'h72) && (r_buf[1] == 8'h64) && (r_buf[2] == 8'h20) &&
                   w_h3[4] && w_h4[4] && w_h5[4] && w_h6[4];
  assign w_wr_ok = !r_lerr && (r_cnt == CNT_W'(10)) &&
                   (r_buf[0] == 8'h77) && (r_buf[1] == 8'h72) && (r_buf[2] == 8'h20) &&
                   w_h3[4] && w_h4[4] && w_h5[4] && w_h6[4] &&
                   (r_buf[7] == 8'h20) && w_h8[4] && w_h9[4];
  assign w_stop_ok = !r_lerr && (r_cnt == CNT_W'(4)) &&
                     (r_buf[0] == 8'h73) && (r_buf[1] == 8'h74) &&
                     (r_buf[2] == 8'h6F) && (r_buf[3] == 8'h70);

  assign w_is_bs      = (iRX_DATA == 8'h08);
  assign w_is_eol     = (iRX_DATA == 8'h0A) || (iRX_DATA == 8'h0D);
  assign w_line_empty = (r_cnt == '0) && !r_lerr;

  // Reply bytes: two payload characters followed by CR LF.
  always_comb begin
    w_tx_byte = 8'h0A;
    case (r_tx_idx)
      2'd0:    w_tx_byte = r_rep0;
      2'd1:    w_tx_byte = r_rep1;
      2'd2:    w_tx_byte = 8'h0D;
      default: w_tx_byte = 8'h0A;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_COLLECT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (iRX_DE && w_is_eol && !w_line_empty) w_state_nxt = S_PARSE;
      S_PARSE:   w_state_nxt = w_rd_ok ? S_READ : (w_wr_ok ? S_WRITE : S_TX);
      S_READ:    if (r_lat_cnt == c_rd_lat) w_state_nxt = S_TX;
      S_WRITE:   w_state_nxt = S_TX;
      S_TX:      if (!r_in_gap && !iTX_BUSY && r_tx_idx == 2'd3) w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  // Line storage; contents beyond r_cnt are don't-care so no reset is needed.
  always_ff @(posedge CLK) begin
    if (r_state == S_COLLECT && iRX_DE && !w_is_bs && !w_is_eol && r_cnt < c_line_max)
      r_buf[r_cnt[IDX_W-1:0]] <= iRX_DATA;
  end

  // Datapath: line edit, bus sequencing, reply build and byte pacing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_lerr    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lat_cnt <= '0;
      r_rep0    <= '0;
      r_rep1    <= '0;
      r_tx_idx  <= '0;
      r_in_gap  <= 1'b0;
      r_gap_cnt <= '0;
      r_tx_de   <= 1'b0;
      r_tx_data <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_tx_de <= 1'b0;
      if (iRX_DE && r_state != S_COLLECT) r_overrun <= 1'b1;
      case (r_state)
        S_COLLECT: begin
          if (iRX_DE) begin
            if (w_is_bs) begin
              if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end else if (!w_is_eol) begin
              if (r_cnt < c_line_max) r_cnt <= r_cnt + 1'b1;
              else                    r_lerr <= 1'b1;
            end
          end
        end
        S_PARSE: begin
          r_tx_idx  <= '0;
          r_in_gap  <= 1'b0;
          r_lat_cnt <= '0;
          if (w_rd_ok) begin
            r_addr <= {w_h3[3:0], w_h4[3:0], w_h5[3:0], w_h6[3:0]};
          end else if (w_wr_ok) begin
            r_addr  <= {w_h3[3:0], w_h4[3:0], w_h5[3:0], w_h6[3:0]};
            r_wdata <= {w_h8[3:0], w_h9[3:0]};
          end else begin
            r_rep0 <= w_stop_ok ? 8'h4F : 8'h4E;  // 'O' / 'N'
            r_rep1 <= w_stop_ok ? 8'h4B : 8'h47;  // 'K' / 'G'
          end
        end
        S_READ: begin
          r_lat_cnt <= r_lat_cnt + 1'b1;
          if (r_lat_cnt == c_rd_lat) begin
            r_rep0 <= to_hex(iREG_RDATA[7:4]);
            r_rep1 <= to_hex(iREG_RDATA[3:0]);
          end
        end
        S_WRITE: begin
          r_rep0 <= 8'h4F;
          r_rep1 <= 8'h4B;
        end
        S_TX: begin
          if (!r_in_gap) begin
            if (!iTX_BUSY) begin
              r_tx_de   <= 1'b1;
              r_tx_data <= w_tx_byte;
              if (r_tx_idx == 2'd3) begin
                r_cnt  <= '0;
                r_lerr <= 1'b0;
              end else begin
                r_tx_idx  <= r_tx_idx + 1'b1;
                r_in_gap  <= 1'b1;
                r_gap_cnt <= '0;
              end
            end
          end else if (r_gap_cnt == c_gap_last) begin
            r_in_gap <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oTX_DE     = r_tx_de;
  assign oTX_DATA   = r_tx_data;
  assign oREG_ADDR  = r_addr;
  assign oREG_WDATA = r_wdata;
  assign oREG_WE    = (r_state == S_WRITE);
  assign oREG_RE    = (r_state == S_READ) && (r_lat_cnt == '0);
  assign oSTOP      = (r_state == S_PARSE) && w_stop_ok;
  assign oOVERRUN   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Directed self-checking bench for uart_cmd_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        iRX_DE = 1'b0;
  logic [7:0]  iRX_DATA = 8'h00;
  logic        oTX_DE;
  logic [7:0]  oTX_DATA;
  logic        iTX_BUSY = 1'b0;
  logic [15:0] oREG_ADDR;
  logic [7:0]  oREG_WDATA;
  logic        oREG_WE;
  logic        oREG_RE;
  logic [7:0]  iREG_RDATA = 8'hEE;
  logic        oSTOP;
  logic        oOVERRUN;

  uart_cmd_ctrl #(.LINE_MAX(16), .RD_LAT(2), .TX_GAP(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .iRX_DE(iRX_DE), .iRX_DATA(iRX_DATA),
    .oTX_DE(oTX_DE), .oTX_DATA(oTX_DATA), .iTX_BUSY(iTX_BUSY),
    .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA), .oREG_WE(oREG_WE),
    .oREG_RE(oREG_RE), .iREG_RDATA(iREG_RDATA), .oSTOP(oSTOP), .oOVERRUN(oOVERRUN)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_errors = 0;
  int         we_cnt = 0, re_cnt = 0, stop_cnt = 0;
  logic [15:0] we_addr = '0, re_addr = '0;
  logic [7:0]  we_data = '0;
  logic [7:0]  tx_q [$];
  logic [7:0]  rd_val = 8'h00;
  logic [2:0]  re_hist = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Observe outputs mid-cycle; read data is presented only on the cycle
  // RD_LAT cycles after the read strobe, garbage otherwise.
  always @(negedge CLK) begin
    if (oREG_WE) begin we_cnt++; we_addr = oREG_ADDR; we_data = oREG_WDATA; end
    if (oREG_RE) begin re_cnt++; re_addr = oREG_ADDR; end
    if (oSTOP)   stop_cnt++;
    if (oTX_DE)  tx_q.push_back(oTX_DATA);
    re_hist    = {re_hist[1:0], oREG_RE};
    iREG_RDATA = re_hist[2] ? rd_val : 8'hEE;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    iRX_DE = 1'b1; iRX_DATA = b;
    @(posedge CLK); #1;
    iRX_DE = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] c0, input logic [7:0] c1);
    for (int i = 0; i < 3000 && tx_q.size() < 4; i++) @(negedge CLK);
    if (tx_q.size() < 4) begin
      chk({tag, "_timeout"}, tx_q.size(), 4);
    end else begin
      chk({tag, "_b0"}, tx_q[0], c0);
      chk({tag, "_b1"}, tx_q[1], c1);
      chk({tag, "_b2"}, tx_q[2], 8'h0D);
      chk({tag, "_b3"}, tx_q[3], 8'h0A);
    end
    tx_q.delete();
    repeat (3) @(negedge CLK);
  endtask

  function automatic logic [63:0] all_outs();
    return {27'd0, oTX_DE, oTX_DATA, oREG_ADDR, oREG_WDATA, oREG_WE, oREG_RE, oSTOP, oOVERRUN};
  endfunction

  initial begin
    int seen;
    repeat (3) @(posedge CLK); #1;
    chk("reset_outs", all_outs(), 64'd0);
    RST_N = 1'b1;

    // 1: read with latency
    rd_val = 8'h3C;
    send_str("rd 0002\n");
    expect_reply("rd1", 8'h33, 8'h43);
    chk("rd1_re_cnt", re_cnt, 1);
    chk("rd1_addr", re_addr, 16'h0002);
    chk("rd1_we_cnt", we_cnt, 0);

    // 2: backspace edit then write
    send_str("rd");
    send_byte(8'h08); send_byte(8'h08);
    send_str("wr 4002 FE\n");
    expect_reply("wr2", 8'h4F, 8'h4B);
    chk("wr2_we_cnt", we_cnt, 1);
    chk("wr2_addr", we_addr, 16'h4002);
    chk("wr2_data", we_data, 8'hFE);
    chk("wr2_re_cnt", re_cnt, 1);
    chk("wr2_hold_addr", oREG_ADDR, 16'h4002);

    // 3: stop
    send_str("stop\n");
    expect_reply("stop3", 8'h4F, 8'h4B);
    chk("stop3_pulses", stop_cnt, 1);
    chk("stop3_bus", we_cnt + re_cnt, 2);

    // 4: malformed commands
    send_str("rd 00G0\n");
    expect_reply("ng4a", 8'h4E, 8'h47);
    send_str("wr 0001 1\n");
    expect_reply("ng4b", 8'h4E, 8'h47);
    chk("ng4_bus", we_cnt + re_cnt, 2);
    chk("ng4_stop", stop_cnt, 1);

    // 5: overlong line, then recovery; lowercase hex in address
    for (int i = 0; i < 20; i++) send_byte(8'h61);
    send_byte(8'h0A);
    expect_reply("long5", 8'h4E, 8'h47);
    rd_val = 8'hA5;
    send_str("rd 0000\n");
    expect_reply("rd5", 8'h41, 8'h35);
    chk("rd5_re_cnt", re_cnt, 2);
    chk("rd5_addr", re_addr, 16'h0000);
    send_str("rd abcD\n");
    expect_reply("rd5b", 8'h41, 8'h35);
    chk("rd5b_addr", re_addr, 16'hABCD);
    chk("no_overrun", oOVERRUN, 1'b0);

    // 6: TX busy stall with RX overrun, then reset mid-reply
    iTX_BUSY = 1'b1;
    send_str("stop\n");
    repeat (40) @(negedge CLK);
    send_byte(8'h78);
    repeat (60) @(negedge CLK);
    chk("busy6_no_tx", tx_q.size(), 0);
    chk("busy6_overrun", oOVERRUN, 1'b1);
    @(posedge CLK); #1 iTX_BUSY = 1'b0;
    expect_reply("busy6", 8'h4F, 8'h4B);
    chk("busy6_overrun_sticky", oOVERRUN, 1'b1);

    send_str("wr 1234 56\n");
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge CLK);
      if (oTX_DE) seen = 1;
    end
    chk("rst6_tx_started", seen, 1);
    #1 RST_N = 1'b0;
    #1 chk("rst6_outs", all_outs(), 64'd0);
    repeat (2) @(posedge CLK); #1 RST_N = 1'b1;
    tx_q.delete();
    repeat (100) @(negedge CLK);
    chk("rst6_abandoned", tx_q.size(), 0);
    send_str("rd 1234\n");
    expect_reply("rst6_rd", 8'h41, 8'h35);
    chk("rst6_rd_addr", re_addr, 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
